// File: rtl/spi_slave_engine.sv
// ---------------------------------------------------------------------------
// spi_slave_engine
//
// Mode-0 SPI slave running entirely in the clk_in domain. The SPI pins are
// brought in through 2-flop synchronizers and edges are found on the
// synchronized copies, so sclk must be at most clk_in/8.
//
// Parameters
//   CHAR_LEN   bits per character (8..32)
//   LSB_FIRST  0 = MSB first, 1 = LSB first (both directions)
//
// Ports
//   clk_in     system clock, rising edge
//   rst_in     asynchronous active-high reset
//   sclk       SPI clock from master (idle low)
//   mosi       SPI data from master
//   ss_n       slave select, active low
//   miso       SPI data to master, 0 while idle
//   tx_data    next character to transmit ([CHAR_LEN-1:0] used)
//   tx_load    one-cycle strobe, writes tx_data into the transmit buffer
//   rx_data    last received character, zero-extended
//   rx_valid   one-cycle pulse when rx_data has been updated
//   busy       high while a frame is in progress
//
// Optional feature (macro SPI_SLAVE_OVERRUN_EN)
//   rx_ack     input, acknowledges the current rx_data
//   rx_overrun sticky flag, set when a character completes while the
//              previous one is still unacknowledged; cleared by reset only
// ---------------------------------------------------------------------------
module spi_slave_engine #(
    parameter int CHAR_LEN  = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso,
    input  logic [31:0] tx_data,
    input  logic        tx_load,
    output logic [31:0] rx_data,
    output logic        rx_valid,
`ifdef SPI_SLAVE_OVERRUN_EN
    input  logic        rx_ack,
    output logic        rx_overrun,
`endif
    output logic        busy
);

    localparam int CNT_W = $clog2(CHAR_LEN);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAR_LEN - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_next;

    logic sclk_meta, sclk_sync, sclk_prev;
    logic ss_meta, ss_sync, ss_prev;
    logic mosi_meta, mosi_sync;
    logic [1:0] settle_cnt;

    logic [CHAR_LEN-1:0] tx_buf;
    logic [CHAR_LEN-1:0] tx_shift;
    logic [CHAR_LEN-1:0] rx_shift;
    logic [CNT_W-1:0]    bit_cnt;

    logic [CHAR_LEN-1:0] tx_next_char;
    logic [CHAR_LEN-1:0] tx_advance;
    logic [CHAR_LEN-1:0] rx_next;
    logic [31:0]         rx_ext;

    logic sync_ready, ss_fall, ss_rise, sclk_rise, sclk_fall;
    logic start_frame, active, char_done;
    logic tx_data_unused;

    // Only the low CHAR_LEN bits of tx_data are meaningful.
    assign tx_data_unused = ^tx_data;

    // Synchronizers for the three SPI inputs plus a one-cycle history for
    // edge detection. settle_cnt blocks the artificial ss_n falling edge
    // that appears while the chain flushes its reset values, so a frame
    // needs a genuine high-to-low transition after reset.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sclk_meta  <= 1'b0;
            sclk_sync  <= 1'b0;
            sclk_prev  <= 1'b0;
            ss_meta    <= 1'b1;
            ss_sync    <= 1'b1;
            ss_prev    <= 1'b1;
            mosi_meta  <= 1'b0;
            mosi_sync  <= 1'b0;
            settle_cnt <= 2'd0;
        end else begin
            sclk_meta <= sclk;
            sclk_sync <= sclk_meta;
            sclk_prev <= sclk_sync;
            ss_meta   <= ss_n;
            ss_sync   <= ss_meta;
            ss_prev   <= ss_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            if (settle_cnt != 2'd3) begin
                settle_cnt <= settle_cnt + 2'd1;
            end
        end
    end

    assign sync_ready = (settle_cnt == 2'd3);
    assign ss_fall    = ss_prev & ~ss_sync & sync_ready;
    assign ss_rise    = ~ss_prev & ss_sync;
    assign sclk_rise  = sclk_sync & ~sclk_prev;
    assign sclk_fall  = ~sclk_sync & sclk_prev;

    // A tx_load in the same cycle as a character load wins over tx_buf.
    assign tx_next_char = tx_load ? tx_data[CHAR_LEN-1:0] : tx_buf;

    assign start_frame = (state == IDLE) && ss_fall;
    assign active      = (state == SHIFT) && !ss_rise;
    assign char_done   = active && sclk_rise && (bit_cnt == LAST_BIT);

    // Shift-direction dependent next values for both shift registers and the
    // zero-extended view of the character that is about to complete.
    always_comb begin
        if (LSB_FIRST) begin
            rx_next    = {mosi_sync, rx_shift[CHAR_LEN-1:1]};
            tx_advance = {1'b0, tx_shift[CHAR_LEN-1:1]};
        end else begin
            rx_next    = {rx_shift[CHAR_LEN-2:0], mosi_sync};
            tx_advance = {tx_shift[CHAR_LEN-2:0], 1'b0};
        end
        rx_ext                 = '0;
        rx_ext[CHAR_LEN-1:0]   = rx_next;
    end

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Frame framing is driven purely by slave select.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ss_fall) state_next = SHIFT;
            SHIFT:   if (ss_rise) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: receive on sclk rising edges, transmit advance on falling
    // edges. A falling edge with the counter back at zero marks the start of
    // the next character, so the transmit register is reloaded instead of
    // shifted, giving gapless back-to-back characters.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            tx_buf   <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (tx_load) begin
                tx_buf <= tx_data[CHAR_LEN-1:0];
            end
            if (start_frame) begin
                tx_shift <= tx_next_char;
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (active) begin
                if (sclk_rise) begin
                    rx_shift <= rx_next;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt  <= '0;
                        rx_data  <= rx_ext;
                        rx_valid <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                if (sclk_fall) begin
                    if (bit_cnt == '0) begin
                        tx_shift <= tx_next_char;
                    end else begin
                        tx_shift <= tx_advance;
                    end
                end
            end
        end
    end

`ifdef SPI_SLAVE_OVERRUN_EN
    logic rx_pending;

    // rx_pending tracks an unacknowledged character; an ack arriving in the
    // same cycle as a completion counts as acknowledging the old one.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_pending <= 1'b0;
            rx_overrun <= 1'b0;
        end else if (char_done) begin
            if (rx_pending && !rx_ack) begin
                rx_overrun <= 1'b1;
            end
            rx_pending <= 1'b1;
        end else if (rx_ack) begin
            rx_pending <= 1'b0;
        end
    end
`endif

    assign busy = (state == SHIFT);
    assign miso = (state == SHIFT) ? (LSB_FIRST ? tx_shift[0] : tx_shift[CHAR_LEN-1]) : 1'b0;

endmodule

// File: tb/tb_spi_slave_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_engine
//
// Drives an MSB-first and an LSB-first instance from one mode-0 master
// (shared sclk/ss_n/tx, separate mosi so each sees data in its own order).
// The master assembles miso bits per the slave's shift order and compares
// against a model of the transmit buffer; received characters are collected
// from rx_valid pulses and compared against what the master sent.
// ---------------------------------------------------------------------------
module tb_spi_slave_engine;

    localparam int CL = 8;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        sclk;
    logic        ss_n;
    logic        mosi_a, mosi_b;
    logic        tx_load;
    logic [31:0] tx_data;
    logic        miso_a, miso_b;
    logic        rx_valid_a, rx_valid_b;
    logic        busy_a, busy_b;
    logic [31:0] rx_data_a, rx_data_b;
`ifdef SPI_SLAVE_OVERRUN_EN
    logic        rx_ack;
    logic        rx_overrun_a, rx_overrun_b;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0]  tx_buf_m;
    logic [31:0] rx_last_m;
    logic [31:0] rx_q_a[$];
    logic [31:0] rx_q_b[$];
    logic [7:0]  mo_chars[0:3];

    spi_slave_engine #(.CHAR_LEN(CL), .LSB_FIRST(1'b0)) dut_a (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sclk     (sclk),
        .mosi     (mosi_a),
        .ss_n     (ss_n),
        .miso     (miso_a),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data_a),
        .rx_valid (rx_valid_a),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun_a),
`endif
        .busy     (busy_a)
    );

    spi_slave_engine #(.CHAR_LEN(CL), .LSB_FIRST(1'b1)) dut_b (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .sclk     (sclk),
        .mosi     (mosi_b),
        .ss_n     (ss_n),
        .miso     (miso_b),
        .tx_data  (tx_data),
        .tx_load  (tx_load),
        .rx_data  (rx_data_b),
        .rx_valid (rx_valid_b),
`ifdef SPI_SLAVE_OVERRUN_EN
        .rx_ack     (rx_ack),
        .rx_overrun (rx_overrun_b),
`endif
        .busy     (busy_b)
    );

    always #5 clk_in = ~clk_in;

    // Collect every received character on the falling clock edge.
    always @(negedge clk_in) begin
        if (rx_valid_a === 1'b1) rx_q_a.push_back(rx_data_a);
        if (rx_valid_b === 1'b1) rx_q_b.push_back(rx_data_b);
    end

    task automatic load_tx(input logic [7:0] v);
        @(negedge clk_in);
        tx_data = ($urandom() & 32'hFFFF_FF00) | {24'h0, v};
        tx_load = 1'b1;
        tx_buf_m = v;
        @(negedge clk_in);
        tx_load = 1'b0;
    endtask

    // Lower ss_n; optionally pulse tx_load exactly in the cycle the slave
    // loads its first character (two cycles of synchronizer latency).
    task automatic ss_start(input bit bypass, input logic [7:0] v);
        ss_n = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        if (bypass) begin
            tx_data  = ($urandom() & 32'hFFFF_FF00) | {24'h0, v};
            tx_load  = 1'b1;
            tx_buf_m = v;
        end
        @(negedge clk_in);
        tx_load = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic ss_end();
        repeat (4) @(negedge clk_in);
        ss_n = 1'b1;
        repeat (8) @(negedge clk_in);
    endtask

    // Transfer nb bits of one character at clk_in/8; the master samples
    // miso at each sclk rising edge. Optionally loads a new tx character
    // during the high phase of the final bit.
    task automatic xfer(input logic [7:0] mo, input int nb, input bit do_load,
                        input logic [7:0] ld, output logic [7:0] got_a,
                        output logic [7:0] got_b);
        got_a = '0;
        got_b = '0;
        for (int i = 0; i < nb; i++) begin
            mosi_a = mo[7-i];
            mosi_b = mo[i];
            repeat (4) @(negedge clk_in);
            sclk = 1'b1;
            got_a[7-i] = miso_a;
            got_b[i]   = miso_b;
            if (do_load && i == nb - 1) begin
                @(negedge clk_in);
                tx_data  = ($urandom() & 32'hFFFF_FF00) | {24'h0, ld};
                tx_load  = 1'b1;
                tx_buf_m = ld;
                @(negedge clk_in);
                tx_load = 1'b0;
                repeat (2) @(negedge clk_in);
            end else begin
                repeat (4) @(negedge clk_in);
            end
            sclk = 1'b0;
        end
    endtask

    // One frame of nchar characters; the last one carries last_bits bits.
    task automatic run_frame(input int nchar, input int last_bits, input bit bypass,
                             input logic [7:0] byp_val, input int load_after,
                             input logic [7:0] load_val, input string name);
        logic [7:0] exp_tx;
        logic [7:0] got_a, got_b;
        int nb;
        int full;
        rx_q_a.delete();
        rx_q_b.delete();
        ss_start(bypass, byp_val);
        checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s busy: got %b/%b expected 1/1", name, busy_a, busy_b);
        end
        for (int k = 0; k < nchar; k++) begin
            exp_tx = tx_buf_m;
            nb = (k == nchar - 1) ? last_bits : CL;
            xfer(mo_chars[k], nb, (k == load_after), load_val, got_a, got_b);
            if (nb == CL) begin
                checks++;
                if (got_a !== exp_tx) begin
                    errors++;
                    $display("[TB] FAIL %s miso_msb char%0d: got %h expected %h", name, k, got_a, exp_tx);
                end
                checks++;
                if (got_b !== exp_tx) begin
                    errors++;
                    $display("[TB] FAIL %s miso_lsb char%0d: got %h expected %h", name, k, got_b, exp_tx);
                end
            end
        end
        ss_end();
        full = (last_bits == CL) ? nchar : nchar - 1;
        checks++;
        if (rx_q_a.size() != full || rx_q_b.size() != full) begin
            errors++;
            $display("[TB] FAIL %s rx_valid count: got %0d/%0d expected %0d", name,
                     rx_q_a.size(), rx_q_b.size(), full);
        end
        for (int k = 0; k < full; k++) begin
            if (k < rx_q_a.size()) begin
                checks++;
                if (rx_q_a[k] !== {24'h0, mo_chars[k]}) begin
                    errors++;
                    $display("[TB] FAIL %s rx_msb char%0d: got %h expected %h", name, k, rx_q_a[k], mo_chars[k]);
                end
            end
            if (k < rx_q_b.size()) begin
                checks++;
                if (rx_q_b[k] !== {24'h0, mo_chars[k]}) begin
                    errors++;
                    $display("[TB] FAIL %s rx_lsb char%0d: got %h expected %h", name, k, rx_q_b[k], mo_chars[k]);
                end
            end
        end
        if (full > 0) rx_last_m = {24'h0, mo_chars[full-1]};
        checks++;
        if (rx_data_a !== rx_last_m || rx_data_b !== rx_last_m) begin
            errors++;
            $display("[TB] FAIL %s rx_data held: got %h/%h expected %h", name, rx_data_a, rx_data_b, rx_last_m);
        end
        checks++;
        if (miso_a !== 1'b0 || miso_b !== 1'b0 || busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s idle miso/busy: got %b%b/%b%b expected 00/00", name,
                     miso_a, miso_b, busy_a, busy_b);
        end
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (miso_a !== 1'b0 || miso_b !== 1'b0 || rx_valid_a !== 1'b0 || rx_valid_b !== 1'b0 ||
            busy_a !== 1'b0 || busy_b !== 1'b0 || rx_data_a !== 32'h0 || rx_data_b !== 32'h0) begin
            errors++;
            $display("[TB] FAIL %s outputs: got miso=%b%b valid=%b%b busy=%b%b rx=%h/%h expected all 0",
                     name, miso_a, miso_b, rx_valid_a, rx_valid_b, busy_a, busy_b, rx_data_a, rx_data_b);
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b0;
        tx_buf_m  = 8'h00;
        rx_last_m = 32'h0;
        repeat (4) @(negedge clk_in);
        check_all_zero("after_reset");
    endtask

    task automatic test_basic();
        load_tx(8'hA5);
        mo_chars[0] = 8'h3C;
        run_frame(1, CL, 1'b0, 8'h00, -1, 8'h00, "basic");
    endtask

    task automatic test_lsb_first();
        load_tx(8'h01);
        mo_chars[0] = 8'h80;
        run_frame(1, CL, 1'b0, 8'h00, -1, 8'h00, "lsb_first");
    endtask

    task automatic test_back_to_back();
        mo_chars[0] = 8'h11;
        mo_chars[1] = 8'h22;
        mo_chars[2] = 8'h33;
        run_frame(3, CL, 1'b0, 8'h00, 0, 8'h55, "back_to_back");
    endtask

    task automatic test_abort();
        mo_chars[0] = 8'($urandom());
        run_frame(1, 5, 1'b0, 8'h00, -1, 8'h00, "abort");
        mo_chars[0] = 8'($urandom());
        run_frame(1, CL, 1'b0, 8'h00, -1, 8'h00, "after_abort");
    endtask

    task automatic test_bypass();
        mo_chars[0] = 8'h96;
        mo_chars[1] = 8'h69;
        run_frame(2, CL, 1'b1, 8'hC6, -1, 8'h00, "bypass");
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] ga, gb;
        load_tx(8'hFF);
        ss_start(1'b0, 8'h00);
        xfer(8'hC3, 3, 1'b0, 8'h00, ga, gb);
        mosi_a = 1'b1;
        mosi_b = 1'b1;
        repeat (4) @(negedge clk_in);
        sclk = 1'b1;
        repeat (2) @(negedge clk_in);
        checks++;
        if (busy_a !== 1'b1 || miso_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_frame busy/miso: got %b/%b expected 1/1", busy_a, miso_a);
        end
        rst_in = 1'b1;
        #1;
        check_all_zero("reset_mid_frame");
        @(negedge clk_in);
        sclk = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b0;
        tx_buf_m  = 8'h00;
        rx_last_m = 32'h0;
        repeat (12) @(negedge clk_in);
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("[TB] FAIL no_stale_start busy: got %b/%b expected 0/0", busy_a, busy_b);
        end
        ss_n = 1'b1;
        repeat (6) @(negedge clk_in);
        mo_chars[0] = 8'($urandom());
        run_frame(1, CL, 1'b0, 8'h00, -1, 8'h00, "post_reset");
    endtask

`ifdef SPI_SLAVE_OVERRUN_EN
    task automatic pulse_ack();
        @(negedge clk_in);
        rx_ack = 1'b1;
        @(negedge clk_in);
        rx_ack = 1'b0;
        @(negedge clk_in);
    endtask

    task automatic check_overrun(input logic exp, input string name);
        checks++;
        if (rx_overrun_a !== exp || rx_overrun_b !== exp) begin
            errors++;
            $display("[TB] FAIL %s rx_overrun: got %b/%b expected %b", name, rx_overrun_a, rx_overrun_b, exp);
        end
    endtask

    task automatic test_overrun();
        pulse_ack();
        check_overrun(1'b0, "ovr_start");
        mo_chars[0] = 8'($urandom());
        run_frame(1, CL, 1'b0, 8'h00, -1, 8'h00, "ovr_first");
        check_overrun(1'b0, "ovr_first");
        mo_chars[0] = 8'($urandom());
        run_frame(1, CL, 1'b0, 8'h00, -1, 8'h00, "ovr_second");
        check_overrun(1'b1, "ovr_second");
        pulse_ack();
        check_overrun(1'b1, "ovr_sticky");
        rst_in = 1'b1;
        #1;
        check_overrun(1'b0, "ovr_reset");
        @(negedge clk_in);
        rst_in = 1'b0;
        tx_buf_m  = 8'h00;
        rx_last_m = 32'h0;
        repeat (6) @(negedge clk_in);
    endtask
`endif

    task automatic test_random();
        int nchar, last_bits, la;
        bit byp;
        for (int f = 0; f < 6; f++) begin
            nchar = int'($urandom_range(1, 3));
            for (int k = 0; k < nchar; k++) mo_chars[k] = 8'($urandom());
            last_bits = (f % 3 == 2) ? int'($urandom_range(1, 7)) : CL;
            la  = int'($urandom_range(0, nchar)) - 1;
            byp = 1'($urandom_range(0, 1));
            run_frame(nchar, last_bits, byp, 8'($urandom()), la, 8'($urandom()), "random");
        end
    endtask

    initial begin
        rst_in  = 1'b1;
        sclk    = 1'b0;
        ss_n    = 1'b1;
        mosi_a  = 1'b0;
        mosi_b  = 1'b0;
        tx_load = 1'b0;
        tx_data = 32'h0;
`ifdef SPI_SLAVE_OVERRUN_EN
        rx_ack  = 1'b0;
`endif
        test_reset();
        test_basic();
        test_lsb_first();
        test_back_to_back();
        test_abort();
        test_bypass();
        test_reset_mid_frame();
`ifdef SPI_SLAVE_OVERRUN_EN
        test_overrun();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_slave_engine.md
SPI_SLAVE_ENGINE -- requirements
Module: spi_slave_engine

Interface
REQ-001 Parameter: CHAR_LEN, 8, bits per character; legal range 8..32.
REQ-002 Parameter: LSB_FIRST, 0, shift order (0 = MSB first, 1 = LSB first) for both directions.
REQ-003 Port: clk_in  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 Port: rst_in  input  1  reset; asynchronous and active-high.
REQ-005 Port: sclk  input  1  SPI serial clock from master (mode 0, asynchronous to clk_in).
REQ-006 Port: mosi  input  1  SPI data from master.
REQ-007 Port: ss_n  input  1  slave select, active-low.
REQ-008 Port: miso  output  1  SPI data to master.
REQ-009 Port: tx_data  input  32  next character to transmit; bits [CHAR_LEN-1:0] used.
REQ-010 Port: tx_load  input  1  one-cycle strobe; writes tx_data into tx_buf.
REQ-011 Port: rx_data  output  32  last received character, zero-extended.
REQ-012 Port: rx_valid  output  1  one-cycle pulse; rx_data updated.
REQ-013 Port: busy  output  1  high while state is SHIFT.

Function
REQ-014 sclk, mosi and ss_n SHALL each pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized signals only.
REQ-015 Supported sclk frequency: up to clk_in/8; high and low phases each >= 3 clk_in cycles.
REQ-016 States: IDLE, SHIFT. IDLE->SHIFT on synchronized ss_n falling edge; SHIFT->IDLE on synchronized ss_n rising edge.
REQ-017 On IDLE->SHIFT: shift register loaded from tx_buf, bit counter cleared, first bit presented on miso in the next cycle.
REQ-018 tx_load asserted in the same cycle as the frame-start load: new tx_data SHALL be used for that character (bypass).
REQ-019 In SHIFT, each synchronized sclk rising edge samples mosi into the receive shift register and increments the bit counter.
REQ-020 In SHIFT, each synchronized sclk falling edge advances the transmit shift register; miso shows the next bit.
REQ-021 On the rising edge that completes CHAR_LEN bits: rx_data loaded, rx_valid pulsed in the following cycle, bit counter wraps to 0.
REQ-022 ss_n still low after a completed character: transmit register reloaded from tx_buf on the next falling edge; back-to-back characters continue without gap.
REQ-023 ss_n deasserted mid-character: partial bits discarded, no rx_valid, rx_data unchanged, return to IDLE.
REQ-024 tx_buf retains its value; without a new tx_load the same character is resent.
REQ-025 miso SHALL be 0 whenever state is IDLE.
REQ-026 sclk edges while ss_n high SHALL be ignored.

Reset
REQ-027 rst_in asserted at any time (including mid-character) SHALL immediately force: state IDLE, miso 0, rx_data 0, rx_valid 0, busy 0, tx_buf 0, counters and shift registers 0, synchronizers to idle values (sclk 0, ss_n 1, mosi 0).
REQ-028 After rst_in release, a frame SHALL start only on a fresh ss_n falling edge.

Configuration
REQ-029 Macro SPI_SLAVE_OVERRUN_EN: when defined, adds output rx_overrun (1 bit), a sticky flag set when rx_valid pulses and the previous rx_data was not acknowledged; an input rx_ack (1 bit) clears the pending state, and rx_overrun clears on reset only.
REQ-030 Without SPI_SLAVE_OVERRUN_EN: neither port exists and rx_data is overwritten silently.

Verification
REQ-031 Reset, tx_load 0xA5, then an 8-bit mode-0 frame with mosi 0x3C at clk_in/8 -> miso shifts 0xA5 MSB first; rx_valid pulses once; rx_data = 0x0000003C.
REQ-032 LSB_FIRST=1, tx_buf 0x01, mosi 0x80 -> master receives 0x01 LSB first; rx_data = 0x80.
REQ-033 ss_n held low for 3 characters (0x11, 0x22, 0x33), tx_load 0x55 after the first -> three rx_valid pulses in order; miso sends the old value, then 0x55, 0x55.
REQ-034 ss_n raised after 5 of 8 bits -> no rx_valid; rx_data holds prior value; next full frame is received correctly.
REQ-035 rst_in pulsed during bit 4 -> all outputs 0 within the same cycle; a following frame sends miso 0x00 (tx_buf cleared).
REQ-036 With SPI_SLAVE_OVERRUN_EN: two characters without rx_ack -> rx_overrun = 1 after the second rx_valid; it stays 1 after rx_ack until rst_in.
